// File: rtl/game_round_ctrl_if.sv
// rtl/game_round_ctrl_if.sv - game round controller signal bundle (stimulus in, game status out)
interface game_round_ctrl_if;
  logic       vs;
  logic       start;
  logic       player_1_hit;
  logic       player_2_hit;
  logic       freeze;
  logic       round_reset;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] winner;
  logic [1:0] state_o;
  logic       round_timeout;

  modport master (
    output vs, start, player_1_hit, player_2_hit,
    input  freeze, round_reset, score_p1, score_p2, winner, state_o, round_timeout
  );

  modport slave (
    input  vs, start, player_1_hit, player_2_hit,
    output freeze, round_reset, score_p1, score_p2, winner, state_o, round_timeout
  );
endinterface

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - two-player arena round sequencer; optional round timer under `ROUND_TIMER_EN
module game_round_ctrl #(
  parameter int WIN_SCORE    = 5,
  parameter int PAUSE_FRAMES = 120,
  parameter int ROUND_FRAMES = 1800
) (
  input logic               Clk,
  input logic               Reset_n,
  game_round_ctrl_if.slave  gif
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAY      = 2'b01,
    HIT_PAUSE = 2'b10,
    OVER      = 2'b11
  } state_t;

`ifdef ROUND_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [11:0] PAUSE_LIMIT = 12'(PAUSE_FRAMES);
  localparam logic [11:0] ROUND_LIMIT = 12'(ROUND_FRAMES);
  localparam logic [3:0]  WIN_LIMIT   = 4'(WIN_SCORE);

  state_t      state, state_n;
  logic [11:0] frame_cnt, frame_cnt_n;
  logic [3:0]  score_p1, score_p1_n;
  logic [3:0]  score_p2, score_p2_n;
  logic [1:0]  winner, winner_n;
  logic        round_reset, round_reset_n;
  logic        timeout, timeout_n;

  logic vs_d, start_d, hit1_d, hit2_d;
  logic frame_tick, start_edge, hit1_edge, hit2_edge;

  // Scores stop at 15 so a mis-set WIN_SCORE can never wrap a display digit.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign frame_tick = gif.vs & ~vs_d;
  assign start_edge = gif.start & ~start_d;
  assign hit1_edge  = gif.player_1_hit & ~hit1_d;
  assign hit2_edge  = gif.player_2_hit & ~hit2_d;

  // Delay taps for edge detection; they track every cycle so a level held across a state change never re-fires.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_d    <= 1'b0;
      start_d <= 1'b0;
      hit1_d  <= 1'b0;
      hit2_d  <= 1'b0;
    end else begin
      vs_d    <= gif.vs;
      start_d <= gif.start;
      hit1_d  <= gif.player_1_hit;
      hit2_d  <= gif.player_2_hit;
    end
  end

  // State, counter, scores and the pulse outputs all register together so round_reset lines up with the PLAY entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      frame_cnt   <= 12'd0;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      winner      <= 2'b00;
      round_reset <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      frame_cnt   <= frame_cnt_n;
      score_p1    <= score_p1_n;
      score_p2    <= score_p2_n;
      winner      <= winner_n;
      round_reset <= round_reset_n;
      timeout     <= timeout_n;
    end
  end

  // Next-state and datapath: hits outrank the round timer, a draw only ends the round.
  always_comb begin
    state_n       = state;
    frame_cnt_n   = frame_cnt;
    score_p1_n    = score_p1;
    score_p2_n    = score_p2;
    winner_n      = winner;
    round_reset_n = 1'b0;
    timeout_n     = 1'b0;

    case (state)
      IDLE: begin
        if (gif.start) begin
          round_reset_n = 1'b1;
          score_p1_n    = 4'd0;
          score_p2_n    = 4'd0;
          winner_n      = 2'b00;
          frame_cnt_n   = 12'd0;
          state_n       = PLAY;
        end
      end

      PLAY: begin
        if (hit1_edge || hit2_edge) begin
          frame_cnt_n = 12'd0;
          state_n     = HIT_PAUSE;
          if (hit2_edge && !hit1_edge) begin
            score_p1_n = sat_inc(score_p1);
            if (score_p1_n == WIN_LIMIT) begin
              state_n  = OVER;
              winner_n = 2'b01;
            end
          end else if (hit1_edge && !hit2_edge) begin
            score_p2_n = sat_inc(score_p2);
            if (score_p2_n == WIN_LIMIT) begin
              state_n  = OVER;
              winner_n = 2'b10;
            end
          end
        end else if (TIMER_EN && (frame_cnt == ROUND_LIMIT)) begin
          timeout_n   = 1'b1;
          frame_cnt_n = 12'd0;
          state_n     = HIT_PAUSE;
        end else if (TIMER_EN && frame_tick) begin
          frame_cnt_n = frame_cnt + 12'd1;
        end
      end

      HIT_PAUSE: begin
        if (frame_cnt == PAUSE_LIMIT) begin
          round_reset_n = 1'b1;
          frame_cnt_n   = 12'd0;
          state_n       = PLAY;
        end else if (frame_tick) begin
          frame_cnt_n = frame_cnt + 12'd1;
        end
      end

      OVER: begin
        if (start_edge) begin
          round_reset_n = 1'b1;
          score_p1_n    = 4'd0;
          score_p2_n    = 4'd0;
          winner_n      = 2'b00;
          frame_cnt_n   = 12'd0;
          state_n       = PLAY;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign gif.freeze        = (state != PLAY);
  assign gif.round_reset   = round_reset;
  assign gif.score_p1      = score_p1;
  assign gif.score_p2      = score_p2;
  assign gif.winner        = winner;
  assign gif.state_o       = state;
  assign gif.round_timeout = timeout;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - scoreboard bench for game_round_ctrl
module tb_game_round_ctrl;
  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3;
`ifdef ROUND_TIMER_EN
  localparam int HOLD_FRAMES = 8;
`else
  localparam int HOLD_FRAMES = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  game_round_ctrl_if gif();

  game_round_ctrl #(.WIN_SCORE(5), .PAUSE_FRAMES(120), .ROUND_FRAMES(10)) dut (
    .Clk(clk), .Reset_n(rst_n), .gif(gif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_cnt  = 0;
  int to_cnt  = 0;
  bit sb_en   = 1'b0;
  logic [1:0] prev_st = 2'd0;
  logic prev_rr = 1'b0;
  logic [11:0] sb[$];
  logic [11:0] exp_ev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] ev(input logic [1:0] st, input logic [3:0] a,
                                     input logic [3:0] b, input logic [1:0] w);
    return {st, a, b, w};
  endfunction

  // Monitor: counts pulses and checks every state change against the scoreboard queue.
  always @(negedge clk) begin
    if (gif.round_reset) rr_cnt++;
    if (gif.round_timeout) to_cnt++;
    if (sb_en && rst_n) begin
      if (gif.round_reset && prev_rr) check("rr_back_to_back", 32'd1, 32'd0);
      if (gif.state_o != prev_st) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 32'(gif.state_o), 32'(prev_st));
        end else begin
          exp_ev = sb.pop_front();
          check("sb_transition", 32'({gif.state_o, gif.score_p1, gif.score_p2, gif.winner}), 32'(exp_ev));
        end
      end
    end
    prev_st = gif.state_o;
    prev_rr = gif.round_reset;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n);
    repeat (n) begin
      step(1); gif.vs = 1'b1;
      step(2); gif.vs = 1'b0;
      step(1);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gif.state_o == s) break;
    end
    check("wait_state", 32'(gif.state_o), 32'(s));
    step(1);
  endtask

  task automatic hit_pulse(input bit p1, input bit p2);
    gif.player_1_hit = p1;
    gif.player_2_hit = p2;
    step(2);
    gif.player_1_hit = 1'b0;
    gif.player_2_hit = 1'b0;
    step(1);
  endtask

  task automatic pause_to_play(input logic [3:0] a, input logic [3:0] b);
    sb.push_back(ev(S_PLAY, a, b, 2'b00));
    frame(120);
    wait_state(S_PLAY, 20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr0;
    gif.vs = 1'b0; gif.start = 1'b0; gif.player_1_hit = 1'b0; gif.player_2_hit = 1'b0;
    step(3);
    check("rst_state", 32'(gif.state_o), 32'(S_IDLE));
    check("rst_freeze", 32'(gif.freeze), 32'd1);
    check("rst_round_reset", 32'(gif.round_reset), 32'd0);
    check("rst_scores", 32'({gif.score_p1, gif.score_p2}), 32'd0);
    check("rst_winner", 32'(gif.winner), 32'd0);
    check("rst_timeout", 32'(gif.round_timeout), 32'd0);
    rst_n = 1'b1;
    step(2);
    sb_en = 1'b1;

    // Start from IDLE, held across several frames.
    sb.push_back(ev(S_PLAY, 4'd0, 4'd0, 2'b00));
    gif.start = 1'b1;
    wait_state(S_PLAY, 10);
    check("start_rr_once", 32'(rr_cnt), 32'd1);
    check("play_freeze", 32'(gif.freeze), 32'd0);
    frame(HOLD_FRAMES);
    check("start_hold_no_rr", 32'(rr_cnt), 32'd1);
    check("start_hold_state", 32'(gif.state_o), 32'(S_PLAY));
    gif.start = 1'b0;

    // Sustained P2 hit scores once, then the pause lasts exactly 120 frames.
    sb.push_back(ev(S_PAUSE, 4'd1, 4'd0, 2'b00));
    gif.player_2_hit = 1'b1;
    step(30);
    gif.player_2_hit = 1'b0;
    check("hold_hit_score", 32'({gif.score_p1, gif.score_p2}), 32'h10);
    check("hold_hit_freeze", 32'(gif.freeze), 32'd1);
    rr0 = rr_cnt;
    frame(119);
    step(4);
    check("pause_119_no_rr", 32'(rr_cnt), 32'(rr0));
    check("pause_119_state", 32'(gif.state_o), 32'(S_PAUSE));
    sb.push_back(ev(S_PLAY, 4'd1, 4'd0, 2'b00));
    frame(1);
    wait_state(S_PLAY, 20);
    check("pause_end_rr", 32'(rr_cnt), 32'(rr0 + 1));

    // Simultaneous hits: draw.
    sb.push_back(ev(S_PAUSE, 4'd1, 4'd0, 2'b00));
    hit_pulse(1'b1, 1'b1);
    check("draw_scores", 32'({gif.score_p1, gif.score_p2}), 32'h10);
    pause_to_play(4'd1, 4'd0);

    // Drive P1 up to four points.
    for (int k = 2; k <= 4; k++) begin
      sb.push_back(ev(S_PAUSE, 4'(k), 4'd0, 2'b00));
      hit_pulse(1'b0, 1'b1);
      pause_to_play(4'(k), 4'd0);
    end

    // Winning hit with start already held: no restart until a fresh press.
    gif.start = 1'b1;
    step(2);
    sb.push_back(ev(S_OVER, 4'd5, 4'd0, 2'b01));
    hit_pulse(1'b0, 1'b1);
    wait_state(S_OVER, 10);
    check("over_winner", 32'(gif.winner), 32'd1);
    check("over_score_p1", 32'(gif.score_p1), 32'd5);
    rr0 = rr_cnt;
    step(5);
    check("over_held_start_state", 32'(gif.state_o), 32'(S_OVER));
    check("over_held_start_rr", 32'(rr_cnt), 32'(rr0));
    gif.start = 1'b0;
    step(3);
    sb.push_back(ev(S_PLAY, 4'd0, 4'd0, 2'b00));
    gif.start = 1'b1;
    wait_state(S_PLAY, 10);
    gif.start = 1'b0;
    check("restart_scores", 32'({gif.score_p1, gif.score_p2, gif.winner}), 32'd0);
    check("restart_rr", 32'(rr_cnt), 32'(rr0 + 1));

`ifdef ROUND_TIMER_EN
    sb.push_back(ev(S_PAUSE, 4'd0, 4'd0, 2'b00));
    frame(10);
    wait_state(S_PAUSE, 10);
    check("timer_pulse", 32'(to_cnt), 32'd1);
    check("timer_scores", 32'({gif.score_p1, gif.score_p2}), 32'd0);
`else
    frame(2000);
    check("no_timer_state", 32'(gif.state_o), 32'(S_PLAY));
    check("no_timer_pulse", 32'(to_cnt), 32'd0);
    sb.push_back(ev(S_PAUSE, 4'd0, 4'd1, 2'b00));
    hit_pulse(1'b1, 1'b0);
    wait_state(S_PAUSE, 10);
`endif

    // Asynchronous reset in the middle of a pause.
    frame(50);
    check("pause_cnt_50", 32'(dut.frame_cnt), 32'd50);
    sb_en = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(gif.state_o), 32'(S_IDLE));
    check("async_rst_freeze", 32'(gif.freeze), 32'd1);
    check("async_rst_scores", 32'({gif.score_p1, gif.score_p2}), 32'd0);
    check("async_rst_cnt", 32'(dut.frame_cnt), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
